// File: rtl/servo_ramp_if.sv
// rtl/servo_ramp_if.sv - command handshake and servo drive signals for servo_ramp_ctrl
interface servo_ramp_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_target;
    logic       busy;
    logic [9:0] cur_n;
    logic       frame_start;
    logic       pwm_out;

    modport master (
        output cmd_valid,
        output cmd_target,
        input  cmd_ready,
        input  busy,
        input  cur_n,
        input  frame_start,
        input  pwm_out
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        output cmd_ready,
        output busy,
        output cur_n,
        output frame_start,
        output pwm_out
    );
endinterface

// File: rtl/servo_ramp_ctrl.sv
// rtl/servo_ramp_ctrl.sv - servo PWM generator that ramps pulse width toward commanded targets
module servo_ramp_ctrl #(
    parameter int CLK_DIV = 500,
    parameter int PERIOD  = 2000,
    parameter int N_MIN   = 100,
    parameter int N_MAX   = 200,
    parameter int N_INIT  = 150,
    parameter int STEP    = 2
) (
    input  logic          clk,
    input  logic          reset,
    servo_ramp_if.slave   bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PER_W = $clog2(PERIOD + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RAMP = 1'b1;

    localparam logic [10:0] MIN11  = 11'(N_MIN);
    localparam logic [10:0] MAX11  = 11'(N_MAX);
    localparam logic [10:0] STEP11 = 11'(STEP);

    logic [DIV_W-1:0] div_cnt;
    logic [PER_W-1:0] period;
    logic [9:0]       cur_n;
    logic [9:0]       target;
    logic [0:0]       state;
    logic             armed;
    logic             pwm_q;

    logic             tick;
    logic             wrap;
    logic             accept;
    logic [10:0]      req;
    logic [10:0]      clamped;
    logic [10:0]      cur11;
    logic [10:0]      tgt11;
    logic [10:0]      next_n;

    assign tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign wrap   = tick && (period == PER_W'(PERIOD));
    assign accept = bus.cmd_valid && bus.cmd_ready;

    assign req   = {1'b0, bus.cmd_target};
    assign cur11 = {1'b0, cur_n};
    assign tgt11 = {1'b0, target};

    always_comb begin
        clamped = req;
        if (req < MIN11)
            clamped = MIN11;
        else if (req > MAX11)
            clamped = MAX11;
    end

    // Step size is min(STEP, distance) so the final step lands exactly on target.
    always_comb begin
        next_n = cur11;
        if (tgt11 > cur11)
            next_n = ((tgt11 - cur11) > STEP11) ? (cur11 + STEP11) : tgt11;
        else if (cur11 > tgt11)
            next_n = ((cur11 - tgt11) > STEP11) ? (cur11 - STEP11) : tgt11;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            period  <= PER_W'(1);
            cur_n   <= 10'(N_INIT);
            target  <= 10'(N_INIT);
            state   <= S_IDLE;
            armed   <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            armed   <= 1'b1;
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick)
                period <= wrap ? PER_W'(1) : period + PER_W'(1);
            pwm_q <= (32'(period) <= 32'(cur_n));

            // cur_n only moves on a wrap so every frame carries one unaltered pulse.
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        target <= clamped[9:0];
                        if (clamped != cur11)
                            state <= S_RAMP;
                    end
                end
                S_RAMP: begin
                    if (wrap) begin
                        cur_n <= next_n[9:0];
                        if (next_n == tgt11)
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = armed && (state == S_IDLE);
    assign bus.busy        = (state == S_RAMP);
    assign bus.cur_n       = cur_n;
    assign bus.frame_start = wrap;
    assign bus.pwm_out     = pwm_q;
endmodule
